isi_pair_sched: RTL and testbench
=================================

# isi_pair_sched

Scheduler that sequences the ISI equality comparator in the landscape-sampling path. It buffers ISI events from two independent sources (X and Y) in small FIFOs and pairs them oldest-first. Each pair is issued to the comparator, and the match result is returned to downstream logic with a valid/ready handshake. It also discards zero ISIs, drops stale unpaired events after a timeout, and keeps saturating match/drop statistics.

## Interface
Parameters:
- BIT_ISI, 8, ISI width.
- DEPTH, 4, entries per input FIFO; power of two, ≥2.
- TIMEOUT, 255, idle cycles an unpaired head entry waits before being dropped; ≥1.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- clr  in  1  reset, asynchronous, active-high.
- x_valid / x_ready  in / out  1  X-source handshake.
- x_isi  in  BIT_ISI  X ISI.
- x_addr  in  1  X comp_addr flag.
- y_valid / y_ready / y_isi / y_addr  same for the Y source.
- cmp_isi_x, cmp_isi_y  out  BIT_ISI  operands to the comparator.
- cmp_addr_x, cmp_addr_y  out  1  address flags to the comparator.
- cmp_issue  out  1  operands valid this cycle.
- cmp_valid  in  1  comparator match flag, registered, 1-cycle latency.
- res_valid / res_ready  out / in  1  result handshake.
- res_match  out  1  comparator verdict for the pair.
- res_isi  out  BIT_ISI  X ISI of the pair.
- match_cnt, drop_cnt, zero_cnt  out  CNT_W  saturating statistics.

## Operation
Input FIFOs:
- x_ready = X FIFO not full; y_ready likewise.
- A handshake with isi == 0 is accepted but not stored; zero_cnt increments.
- A push on a full FIFO cannot occur, since ready is low.
- A push and a pop in the same cycle are both honoured.

FSM states are IDLE, ISSUE, CAPT, OUT.
- IDLE: if both FIFOs are non-empty, pop both heads into the cmp_* operand registers and go to ISSUE.
- ISSUE: cmp_issue = 1; operands are stable. Go to CAPT unconditionally.
- CAPT:
  - Register cmp_valid into res_match and cmp_isi_x into res_isi.
  - If cmp_valid, match_cnt increments.
  - Go to OUT.
- OUT: res_valid = 1; res_match and res_isi are held. On res_ready, go to IDLE.

Timeout (IDLE only):
- to_cnt increments each IDLE cycle in which exactly one FIFO is non-empty.
- When to_cnt == TIMEOUT: that FIFO's head is popped and discarded, drop_cnt increments, and to_cnt clears.
- to_cnt clears when both FIFOs are empty, when a pair is popped, or outside IDLE.
- to_cnt does not count outside IDLE.

Rules:
- Pairing is strictly FIFO order; there is no reordering.
- cmp_* operand registers hold their last values outside ISSUE.
- All counters saturate at 2^CNT_W − 1 and do not wrap.

## Timing
Reset values:
- All outputs are 0, except x_ready = y_ready = 1.
- FSM in IDLE; FIFOs empty; to_cnt = 0.

Pair path:
- The FIFO entry is poppable the cycle after its push (no bypass).
- Pop in IDLE at edge E; cmp_issue is high in cycle E+1.
- cmp_valid is sampled at the end of CAPT (cycle E+2).
- res_valid is high from cycle E+3.
- Peak throughput is one pair per 4 cycles with res_ready tied high.

Timeout path:
- With TIMEOUT = T, a lone entry is dropped T+1 cycles after it becomes the IDLE head (T counting cycles plus the drop cycle).

Boundary conditions:
- An arrival on the empty side in the same cycle as the drop does not prevent the drop.
- Asserting clr mid-operation (any state) empties both FIFOs, returns the FSM to IDLE and zeroes all counters. No partial result is emitted.

## Structure
- Shared package isi_sched_pkg holds the state enum (IDLE, ISSUE, CAPT, OUT) and default parameter constants.
- One sub-module, isi_fifo: parameterised synchronous FIFO with BIT_ISI+1 data bits, push/pop, full/empty and async clr. It is instantiated twice.
- The comparator is external and is connected at the level above this block.

## Test plan
- **Basic match.** X sends (isi 5, addr 0) and Y sends (isi 5, addr 0); comparator model replies with cmp_valid = 1. Required: cmp_issue pulses once with 5/5, res_valid with res_match = 1 and res_isi = 5, match_cnt = 1.
- **Ordered pairing.** X sends 3, 7, 9 and Y sends 3, 8, 9, with res_ready high. Required: three results in order, match = 1/0/1, match_cnt = 2.
- **Timeout.** TIMEOUT = 4, only X sends isi 6. Required: dropped 5 cycles after it becomes the IDLE head, drop_cnt = 1, no cmp_issue.
- **Zero and full.** X sends isi 0, then DEPTH+1 non-zero values with Y idle and a large TIMEOUT. Required: zero_cnt = 1, x_ready low after DEPTH entries, no overflow.
- **Backpressure.** res_ready low for 10 cycles with pairs queued. Required: res_valid and the result stay stable, no further cmp_issue, FIFOs keep accepting until full.
- **Reset mid-op.** Assert clr during ISSUE. Required: all outputs at reset values the next cycle, no res_valid afterwards until new input arrives.

Source files
------------

// File: rtl/isi_sched_pkg.sv
// ----------------------------------------------------------------------------
// isi_sched_pkg: shared state encoding and default sizing for the ISI pair scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package isi_sched_pkg;

  localparam int BIT_ISI_DEF = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/isi_fifo.sv
// ----------------------------------------------------------------------------
// isi_fifo: synchronous FIFO with wrap-bit pointers, no read bypass.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module isi_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/isi_pair_sched.sv
// ----------------------------------------------------------------------------
// isi_pair_sched: pairs X/Y ISI events oldest-first, issues them to the comparator.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module isi_pair_sched
  import isi_sched_pkg::*;
#(
  parameter int BIT_ISI = BIT_ISI_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [BIT_ISI-1:0] x_isi,
  input  logic               x_addr,
  input  logic               y_valid,
  output logic               y_ready,
  input  logic [BIT_ISI-1:0] y_isi,
  input  logic               y_addr,
  output logic [BIT_ISI-1:0] cmp_isi_x,
  output logic [BIT_ISI-1:0] cmp_isi_y,
  output logic               cmp_addr_x,
  output logic               cmp_addr_y,
  output logic               cmp_issue,
  input  logic               cmp_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_match,
  output logic [BIT_ISI-1:0] res_isi,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   zero_cnt
);

  localparam int DW   = BIT_ISI + 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [BIT_ISI-1:0] cmp_isi_x_q, cmp_isi_x_d, cmp_isi_y_q, cmp_isi_y_d;
  logic               cmp_addr_x_q, cmp_addr_x_d, cmp_addr_y_q, cmp_addr_y_d;
  logic               res_match_q, res_match_d;
  logic [BIT_ISI-1:0] res_isi_q, res_isi_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d, drop_cnt_q, drop_cnt_d, zero_cnt_q, zero_cnt_d;
  logic [CNT_W:0]     zero_sum;

  logic          x_push, y_push, x_zero, y_zero, x_pop, y_pop;
  logic          x_full, y_full, x_empty, y_empty;
  logic [DW-1:0] x_head, y_head;

  assign x_ready = !x_full;
  assign y_ready = !y_full;
  // Zero ISIs complete the handshake but are never stored.
  assign x_push  = x_valid && x_ready && (x_isi != '0);
  assign y_push  = y_valid && y_ready && (y_isi != '0);
  assign x_zero  = x_valid && x_ready && (x_isi == '0);
  assign y_zero  = y_valid && y_ready && (y_isi == '0);

  isi_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo_x (
    .clk   (clk),
    .clr   (clr),
    .push  (x_push),
    .din   ({x_addr, x_isi}),
    .pop   (x_pop),
    .dout  (x_head),
    .full  (x_full),
    .empty (x_empty)
  );

  isi_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo_y (
    .clk   (clk),
    .clr   (clr),
    .push  (y_push),
    .din   ({y_addr, y_isi}),
    .pop   (y_pop),
    .dout  (y_head),
    .full  (y_full),
    .empty (y_empty)
  );

  assign zero_sum = {1'b0, zero_cnt_q} + (CNT_W+1)'(x_zero) + (CNT_W+1)'(y_zero);

  always_comb begin
    state_d      = state_q;
    to_cnt_d     = '0;
    x_pop        = 1'b0;
    y_pop        = 1'b0;
    cmp_isi_x_d  = cmp_isi_x_q;
    cmp_isi_y_d  = cmp_isi_y_q;
    cmp_addr_x_d = cmp_addr_x_q;
    cmp_addr_y_d = cmp_addr_y_q;
    res_match_d  = res_match_q;
    res_isi_d    = res_isi_q;
    match_cnt_d  = match_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    zero_cnt_d   = zero_sum[CNT_W] ? '1 : zero_sum[CNT_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (!x_empty && !y_empty) begin
          x_pop        = 1'b1;
          y_pop        = 1'b1;
          cmp_isi_x_d  = x_head[BIT_ISI-1:0];
          cmp_isi_y_d  = y_head[BIT_ISI-1:0];
          cmp_addr_x_d = x_head[BIT_ISI];
          cmp_addr_y_d = y_head[BIT_ISI];
          state_d      = ISSUE;
        end else if (!x_empty || !y_empty) begin
          // Exactly one side holds a head; age it out once it has waited TIMEOUT cycles.
          if (to_cnt_q == TO_W'(TIMEOUT)) begin
            x_pop      = !x_empty;
            y_pop      = !y_empty;
            drop_cnt_d = (drop_cnt_q == '1) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        res_match_d = cmp_valid;
        res_isi_d   = cmp_isi_x_q;
        if (cmp_valid) begin
          match_cnt_d = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + CNT_W'(1);
        end
        state_d = OUT;
      end
      OUT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      to_cnt_q     <= '0;
      cmp_isi_x_q  <= '0;
      cmp_isi_y_q  <= '0;
      cmp_addr_x_q <= 1'b0;
      cmp_addr_y_q <= 1'b0;
      res_match_q  <= 1'b0;
      res_isi_q    <= '0;
      match_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      zero_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      cmp_isi_x_q  <= cmp_isi_x_d;
      cmp_isi_y_q  <= cmp_isi_y_d;
      cmp_addr_x_q <= cmp_addr_x_d;
      cmp_addr_y_q <= cmp_addr_y_d;
      res_match_q  <= res_match_d;
      res_isi_q    <= res_isi_d;
      match_cnt_q  <= match_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      zero_cnt_q   <= zero_cnt_d;
    end
  end

  assign cmp_issue  = (state_q == ISSUE);
  assign res_valid  = (state_q == OUT);
  assign cmp_isi_x  = cmp_isi_x_q;
  assign cmp_isi_y  = cmp_isi_y_q;
  assign cmp_addr_x = cmp_addr_x_q;
  assign cmp_addr_y = cmp_addr_y_q;
  assign res_match  = res_match_q;
  assign res_isi    = res_isi_q;
  assign match_cnt  = match_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign zero_cnt   = zero_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_isi_pair_sched.sv
// ----------------------------------------------------------------------------
// tb_isi_pair_sched: directed scoreboard bench with a registered equality comparator model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_isi_pair_sched;

  localparam int BIT_ISI = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               clr = 1'b1;
  logic               x_valid = 1'b0, y_valid = 1'b0;
  logic               x_ready, y_ready;
  logic [BIT_ISI-1:0] x_isi = '0, y_isi = '0;
  logic               x_addr = 1'b0, y_addr = 1'b0;
  logic [BIT_ISI-1:0] cmp_isi_x, cmp_isi_y;
  logic               cmp_addr_x, cmp_addr_y, cmp_issue;
  logic               cmp_valid = 1'b0;
  logic               res_valid, res_match;
  logic               res_ready = 1'b1;
  logic [BIT_ISI-1:0] res_isi;
  logic [CNT_W-1:0]   match_cnt, drop_cnt, zero_cnt;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       ax;
    logic       ay;
    logic       m;
  } exp_t;

  exp_t exp_q[$];
  exp_t iss_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   issue_seen  = 0;

  isi_pair_sched #(
    .BIT_ISI (BIT_ISI),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_isi      (x_isi),
    .x_addr     (x_addr),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .y_isi      (y_isi),
    .y_addr     (y_addr),
    .cmp_isi_x  (cmp_isi_x),
    .cmp_isi_y  (cmp_isi_y),
    .cmp_addr_x (cmp_addr_x),
    .cmp_addr_y (cmp_addr_y),
    .cmp_issue  (cmp_issue),
    .cmp_valid  (cmp_valid),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_match  (res_match),
    .res_isi    (res_isi),
    .match_cnt  (match_cnt),
    .drop_cnt   (drop_cnt),
    .zero_cnt   (zero_cnt)
  );

  always #5 clk = ~clk;

  // External comparator: registered, one cycle after the issue cycle.
  always @(posedge clk) begin
    cmp_valid <= cmp_issue && (cmp_isi_x == cmp_isi_y) && (cmp_addr_x == cmp_addr_y);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (cmp_issue) begin
        exp_t e;
        issue_seen++;
        chk("issue_expected", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          chk("cmp_isi_x", 32'(cmp_isi_x), 32'(e.x));
          chk("cmp_isi_y", 32'(cmp_isi_y), 32'(e.y));
          chk("cmp_addr", 32'({cmp_addr_x, cmp_addr_y}), 32'({e.ax, e.ay}));
        end
      end
      if (res_valid && res_ready) begin
        exp_t e;
        chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_isi", 32'(res_isi), 32'(e.x));
          chk("res_match", 32'(res_match), 32'(e.m));
        end
      end
    end
  end

  task automatic drive_x(input logic [7:0] v, input logic a);
    int n = 0;
    @(negedge clk);
    x_valid = 1'b1; x_isi = v; x_addr = a;
    while (!x_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("x_accept", 32'(x_ready), 32'd1);
    @(posedge clk);
    #1 x_valid = 1'b0;
  endtask

  task automatic drive_y(input logic [7:0] v, input logic a);
    int n = 0;
    @(negedge clk);
    y_valid = 1'b1; y_isi = v; y_addr = a;
    while (!y_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("y_accept", 32'(y_ready), 32'd1);
    @(posedge clk);
    #1 y_valid = 1'b0;
  endtask

  function automatic exp_t mk(input logic [7:0] xv, input logic xa, input logic [7:0] yv, input logic ya);
    exp_t e;
    e.x  = xv;
    e.y  = yv;
    e.ax = xa;
    e.ay = ya;
    e.m  = (xv == yv) && (xa == ya);
    return e;
  endfunction

  task automatic send_pair(input logic [7:0] xv, input logic xa, input logic [7:0] yv, input logic ya);
    exp_q.push_back(mk(xv, xa, yv, ya));
    iss_q.push_back(mk(xv, xa, yv, ya));
    fork
      drive_x(xv, xa);
      drive_y(yv, ya);
    join
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(exp_q.size() + iss_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("rst_x_ready", 32'(x_ready), 32'd1);
    chk("rst_y_ready", 32'(y_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmp_issue", 32'(cmp_issue), 32'd0);
    chk("rst_counters", 32'({match_cnt, drop_cnt} | 32'(zero_cnt)), 32'd0);
    chk("rst_cmp_isi", 32'({cmp_isi_x, cmp_isi_y}), 32'd0);
    chk("rst_res", 32'({res_isi, res_match}), 32'd0);

    // basic match
    base = issue_seen;
    send_pair(8'd5, 1'b0, 8'd5, 1'b0);
    wait_drain(50);
    chk("basic_match_cnt", 32'(match_cnt), 32'd1);
    chk("basic_issue_once", 32'(issue_seen - base), 32'd1);

    // ordered pairing
    send_pair(8'd3, 1'b0, 8'd3, 1'b0);
    send_pair(8'd7, 1'b0, 8'd8, 1'b0);
    send_pair(8'd9, 1'b0, 8'd9, 1'b0);
    wait_drain(100);
    chk("order_match_cnt", 32'(match_cnt), 32'd3);

    // timeout: lone X entry dropped TIMEOUT+1 cycles after becoming head
    base = issue_seen;
    drive_x(8'd6, 1'b0);
    repeat (4) @(posedge clk);
    #1 chk("to_not_yet", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1 chk("to_dropped", 32'(drop_cnt), 32'd1);

    // Y arrives on the drop edge of a lone X: drop still happens, Y ages out later
    drive_x(8'd9, 1'b0);
    repeat (4) @(posedge clk);
    drive_y(8'd2, 1'b0);
    chk("to_arrival_drop", 32'(drop_cnt), 32'd2);
    repeat (4) @(posedge clk);
    #1 chk("to_y_not_yet", 32'(drop_cnt), 32'd2);
    @(posedge clk);
    #1 chk("to_y_dropped", 32'(drop_cnt), 32'd3);
    chk("to_no_issue", 32'(issue_seen - base), 32'd0);

    // zero ISI and full FIFO
    drive_x(8'd0, 1'b0);
    chk("zero_cnt", 32'(zero_cnt), 32'd1);
    for (int v = 1; v <= DEPTH; v++) drive_x(8'(v), 1'b0);
    chk("x_full_ready", 32'(x_ready), 32'd0);
    fork
      drive_x(8'd5, 1'b0);
      begin
        for (int v = 1; v <= 5; v++) begin
          exp_q.push_back(mk(8'(v), 1'b0, 8'(v), 1'b0));
          iss_q.push_back(mk(8'(v), 1'b0, 8'(v), 1'b0));
          drive_y(8'(v), 1'b0);
        end
      end
    join
    wait_drain(200);
    chk("full_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("full_match_cnt", 32'(match_cnt), 32'd8);
    chk("full_zero_cnt", 32'(zero_cnt), 32'd1);

    // backpressure
    res_ready = 1'b0;
    base = issue_seen;
    send_pair(8'd10, 1'b0, 8'd10, 1'b0);
    send_pair(8'd11, 1'b0, 8'd12, 1'b0);
    send_pair(8'd13, 1'b1, 8'd13, 1'b1);
    send_pair(8'd20, 1'b0, 8'd20, 1'b0);
    send_pair(8'd21, 1'b0, 8'd21, 1'b1);
    chk("bp_x_full", 32'(x_ready), 32'd0);
    chk("bp_y_full", 32'(y_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_isi", 32'(res_isi), 32'd10);
      chk("bp_res_match", 32'(res_match), 32'd1);
    end
    chk("bp_issue_count", 32'(issue_seen - base), 32'd1);
    res_ready = 1'b1;
    wait_drain(200);
    chk("bp_match_cnt", 32'(match_cnt), 32'd11);

    // reset during ISSUE
    send_pair(8'd30, 1'b0, 8'd30, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmp_issue && n < 20);
    chk("mid_issue_reached", 32'(cmp_issue), 32'd1);
    #2 clr = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_cmp_issue", 32'(cmp_issue), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_counters", 32'({match_cnt, drop_cnt} | 32'(zero_cnt)), 32'd0);
    chk("mid_ready", 32'({x_ready, y_ready}), 32'd3);
    chk("mid_cmp_isi", 32'({cmp_isi_x, cmp_isi_y}), 32'd0);
    chk("mid_res", 32'({res_isi, res_match}), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    iss_q.delete();
    repeat (8) @(posedge clk);
    #1 chk("mid_no_result", 32'(res_valid), 32'd0);
    send_pair(8'd40, 1'b0, 8'd41, 1'b0);
    wait_drain(50);
    chk("post_match_cnt", 32'(match_cnt), 32'd0);
    chk("post_res_isi", 32'(res_isi), 32'd40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
